multicycle_ctrl: RTL and testbench

- FSM controller that sequences the existing datapath (register file, extender, ALU, PC, one shared instruction/data memory) as a multicycle CPU.
- Supports the same 15-instruction subset as the single-cycle control: add, addi, addu, sub, subu, and, or, sll, lw, sw, beq, bne, bgtz, slt, sltu.
- Memory is reached through a req/ready handshake, so variable-latency memory can stall any access.
- Drives the existing datapath control signal set, plus pc_wr, ir_wr, IorD and the memory handshake.

---
 rtl/multicycle_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller: FETCH/DECODE/EXEC/MEM/WB FSM driving the shared-memory datapath.
// Optional performance counters are enabled by defining MULTICYCLE_CTRL_PERF_EN.

module multicycle_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  op,
   input  logic [5:0]  fun,
   input  logic        equal,
   input  logic        sign,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        MemWr,
   output logic        IorD,
   output logic        ir_wr,
   output logic        pc_wr,
   output logic        nPC_sel,
   output logic        RegWr,
   output logic        RegDst,
   output logic        ExtOp,
   output logic        ALUSrc,
   output logic        MemtoReg,
   output logic [2:0]  ALUctr,
   output logic        illegal,
   output logic [2:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt,
   output logic [31:0] stall_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      C_RTYPE,
      C_ADDI,
      C_LW,
      C_SW,
      C_BEQ,
      C_BNE,
      C_BGTZ,
      C_ILLEGAL
   } instr_class_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;

   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;

   localparam logic [2:0] ALU_AND  = 3'd0;
   localparam logic [2:0] ALU_OR   = 3'd1;
   localparam logic [2:0] ALU_ADD  = 3'd2;
   localparam logic [2:0] ALU_SLT  = 3'd3;
   localparam logic [2:0] ALU_ADDU = 3'd4;
   localparam logic [2:0] ALU_SLL  = 3'd5;
   localparam logic [2:0] ALU_SUB  = 3'd6;
   localparam logic [2:0] ALU_SLTU = 3'd7;

   function automatic logic isRtypeFun(input logic [5:0] a_fun);
      case (a_fun)
         FN_SLL, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
         FN_AND, FN_OR, FN_SLT, FN_SLTU: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

   function automatic instr_class_e classify(input logic [5:0] a_op, input logic [5:0] a_fun);
      case (a_op)
         OP_RTYPE: return isRtypeFun(a_fun) ? C_RTYPE : C_ILLEGAL;
         OP_ADDI:  return C_ADDI;
         OP_LW:    return C_LW;
         OP_SW:    return C_SW;
         OP_BEQ:   return C_BEQ;
         OP_BNE:   return C_BNE;
         OP_BGTZ:  return C_BGTZ;
         default:  return C_ILLEGAL;
      endcase
   endfunction

   function automatic logic [2:0] rtypeAluCtr(input logic [5:0] a_fun);
      case (a_fun)
         FN_ADD:  return ALU_ADD;
         FN_ADDU: return ALU_ADDU;
         FN_SUB:  return ALU_SUB;
         FN_SUBU: return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         FN_SLTU: return ALU_SLTU;
         default: return ALU_SLL;
      endcase
   endfunction

   state_e       r_state;
   state_e       w_nextState;
   logic [5:0]   r_opQ;
   logic [5:0]   r_funQ;
   instr_class_e w_decClass;
   instr_class_e w_class;
   logic         w_branchTaken;

   // DECODE classifies the live IR fields; later states only see the latched copy.
   assign w_decClass = classify(op, fun);
   assign w_class    = classify(r_opQ, r_funQ);

   always_comb begin
      w_branchTaken = 1'b0;
      case (w_class)
         C_BEQ:   w_branchTaken = equal;
         C_BNE:   w_branchTaken = ~equal;
         C_BGTZ:  w_branchTaken = ~(equal | sign);
         default: w_branchTaken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_opQ   <= '0;
         r_funQ  <= '0;
      end else begin
         r_state <= w_nextState;
         if (r_state == S_DECODE) begin
            r_opQ  <= op;
            r_funQ <= fun;
         end
      end
   end

   always_comb begin
      w_nextState = r_state;
      mem_req     = 1'b0;
      MemWr       = 1'b0;
      IorD        = 1'b0;
      ir_wr       = 1'b0;
      pc_wr       = 1'b0;
      nPC_sel     = 1'b0;
      RegWr       = 1'b0;
      RegDst      = 1'b0;
      ExtOp       = 1'b0;
      ALUSrc      = 1'b0;
      MemtoReg    = 1'b0;
      ALUctr      = ALU_AND;
      illegal     = 1'b0;
      state       = r_state;

      // ALU controls are a pure function of the latched instruction from EXEC through WB.
      if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
         case (w_class)
            C_RTYPE: begin
               ALUSrc = 1'b0;
               ALUctr = rtypeAluCtr(r_funQ);
            end
            C_ADDI: begin
               ALUSrc = 1'b1;
               ExtOp  = 1'b1;
               ALUctr = ALU_ADD;
            end
            C_LW, C_SW: begin
               ALUSrc = 1'b1;
               ExtOp  = 1'b1;
               ALUctr = ALU_ADDU;
            end
            C_BEQ, C_BNE, C_BGTZ: begin
               ALUSrc = 1'b0;
               ALUctr = ALU_SUB;
            end
            default: ;
         endcase
      end

      case (r_state)
         S_FETCH: begin
            mem_req = 1'b1;
            IorD    = 1'b0;
            ALUctr  = ALU_ADDU;
            if (mem_ready) begin
               ir_wr       = 1'b1;
               pc_wr       = 1'b1;
               nPC_sel     = 1'b0;
               w_nextState = S_DECODE;
            end
         end
         S_DECODE: begin
            if (w_decClass == C_ILLEGAL) begin
               illegal     = 1'b1;
               w_nextState = S_FETCH;
            end else begin
               w_nextState = S_EXEC;
            end
         end
         S_EXEC: begin
            case (w_class)
               C_RTYPE, C_ADDI: w_nextState = S_WB;
               C_LW, C_SW:      w_nextState = S_MEM;
               default: begin
                  pc_wr       = w_branchTaken;
                  nPC_sel     = w_branchTaken;
                  w_nextState = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            IorD    = 1'b1;
            MemWr   = (w_class == C_SW);
            if (mem_ready) begin
               w_nextState = (w_class == C_SW) ? S_FETCH : S_WB;
            end
         end
         S_WB: begin
            RegWr       = 1'b1;
            RegDst      = (w_class == C_RTYPE);
            MemtoReg    = (w_class == C_LW);
            w_nextState = S_FETCH;
         end
         default: w_nextState = S_FETCH;
      endcase

      // Reset silences every output immediately, so an in-flight store cannot write.
      if (reset) begin
         mem_req  = 1'b0;
         MemWr    = 1'b0;
         IorD     = 1'b0;
         ir_wr    = 1'b0;
         pc_wr    = 1'b0;
         nPC_sel  = 1'b0;
         RegWr    = 1'b0;
         RegDst   = 1'b0;
         ExtOp    = 1'b0;
         ALUSrc   = 1'b0;
         MemtoReg = 1'b0;
         ALUctr   = 3'd0;
         illegal  = 1'b0;
         state    = 3'd0;
      end
   end

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] r_cycleCnt;
   logic [31:0] r_instrCnt;
   logic [31:0] r_stallCnt;
   logic        w_decodeToExec;

   assign w_decodeToExec = (r_state == S_DECODE) && (w_nextState == S_EXEC);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycleCnt <= '0;
         r_instrCnt <= '0;
         r_stallCnt <= '0;
      end else begin
         r_cycleCnt <= r_cycleCnt + 32'd1;
         if (w_decodeToExec) begin
            r_instrCnt <= r_instrCnt + 32'd1;
         end
         if (mem_req && !mem_ready) begin
            r_stallCnt <= r_stallCnt + 32'd1;
         end
      end
   end

   assign cycle_cnt = r_cycleCnt;
   assign instr_cnt = r_instrCnt;
   assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl; define MULTICYCLE_CTRL_PERF_EN to also cover the counters.

module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  op;
   logic [5:0]  fun;
   logic        equal;
   logic        sign;
   logic        mem_ready;
   logic        mem_req, MemWr, IorD, ir_wr, pc_wr, nPC_sel;
   logic        RegWr, RegDst, ExtOp, ALUSrc, MemtoReg, illegal;
   logic [2:0]  ALUctr;
   logic [2:0]  state;
`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instr_cnt, stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .fun       (fun),
      .equal     (equal),
      .sign      (sign),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .MemWr     (MemWr),
      .IorD      (IorD),
      .ir_wr     (ir_wr),
      .pc_wr     (pc_wr),
      .nPC_sel   (nPC_sel),
      .RegWr     (RegWr),
      .RegDst    (RegDst),
      .ExtOp     (ExtOp),
      .ALUSrc    (ALUSrc),
      .MemtoReg  (MemtoReg),
      .ALUctr    (ALUctr),
      .illegal   (illegal),
      .state     (state)
`ifdef MULTICYCLE_CTRL_PERF_EN
      ,
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   // Output vector: req wr iord irw pcw npc regwr regdst ext src m2r ctr[2:0] ill state[2:0]
   logic [17:0] obs;
   assign obs = {mem_req, MemWr, IorD, ir_wr, pc_wr, nPC_sel, RegWr, RegDst,
                 ExtOp, ALUSrc, MemtoReg, ALUctr, illegal, state};

   localparam logic [17:0] B_REQ    = 18'h20000;
   localparam logic [17:0] B_MEMWR  = 18'h10000;
   localparam logic [17:0] B_IORD   = 18'h08000;
   localparam logic [17:0] B_IRW    = 18'h04000;
   localparam logic [17:0] B_PCW    = 18'h02000;
   localparam logic [17:0] B_NPC    = 18'h01000;
   localparam logic [17:0] B_REGWR  = 18'h00800;
   localparam logic [17:0] B_REGDST = 18'h00400;
   localparam logic [17:0] B_EXT    = 18'h00200;
   localparam logic [17:0] B_SRC    = 18'h00100;
   localparam logic [17:0] B_M2R    = 18'h00080;
   localparam logic [17:0] B_ILL    = 18'h00008;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_BGTZ = 6'b000111;
   localparam logic [5:0] F_ADD   = 6'b100000;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  fun;
      logic        mr;
      logic        eq;
      logic        sg;
      logic [17:0] exp;
   } row_t;

   function automatic logic [17:0] cs(input logic [2:0] c, input logic [2:0] s);
      return {11'b0, c, 1'b0, s};
   endfunction

   function automatic row_t mkRow(input logic rst, input logic [5:0] o, input logic [5:0] f,
                                  input logic mr, input logic eq, input logic sg,
                                  input logic [17:0] e);
      row_t r;
      r.rst = rst; r.op = o; r.fun = f; r.mr = mr; r.eq = eq; r.sg = sg; r.exp = e;
      return r;
   endfunction

   task automatic drive(input row_t r);
      reset     = r.rst;
      op        = r.op;
      fun       = r.fun;
      mem_ready = r.mr;
      equal     = r.eq;
      sign      = r.sg;
   endtask

   // FETCH with memory ready, FETCH waiting, and a plain DECODE cycle
   function automatic logic [17:0] eGo();
      return B_REQ | B_IRW | B_PCW | cs(3'd4, 3'd0);
   endfunction
   function automatic logic [17:0] eWait();
      return B_REQ | cs(3'd4, 3'd0);
   endfunction
   function automatic logic [17:0] eDec();
      return cs(3'd0, 3'd1);
   endfunction

   task automatic test_reset();
      reset = 1'b1; op = 6'h3f; fun = 6'h00; mem_ready = 1'b1; equal = 1'b0; sign = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs !== 18'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 18'h0);
      end
      op = OP_SW; mem_ready = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (obs !== 18'h0) begin
         errors++;
         $display("[TB] FAIL reset_hold: got %h expected %h", obs, 18'h0);
      end
   endtask

   task automatic test_zero_wait_add();
      row_t rows[$];
      rows.push_back(mkRow(0, OP_R, F_ADD, 1, 0, 0, eGo()));
      rows.push_back(mkRow(0, OP_R, F_ADD, 1, 0, 0, eDec()));
      rows.push_back(mkRow(0, OP_R, F_ADD, 1, 0, 0, cs(3'd2, 3'd2)));
      rows.push_back(mkRow(0, OP_R, F_ADD, 1, 0, 0, B_REGWR | B_REGDST | cs(3'd2, 3'd4)));
      rows.push_back(mkRow(0, OP_R, F_ADD, 0, 0, 0, eWait()));
      foreach (rows[i]) begin
         drive(rows[i]); #1;
         checks++;
         if (obs !== rows[i].exp) begin
            errors++;
            $display("[TB] FAIL add_zero_wait row %0d: got %h expected %h", i, obs, rows[i].exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_lw_stall();
      row_t rows[$];
      logic [17:0] eMem;
      eMem = B_REQ | B_IORD | B_EXT | B_SRC | cs(3'd4, 3'd3);
      rows.push_back(mkRow(0, OP_LW, 6'h00, 1, 0, 0, eGo()));
      rows.push_back(mkRow(0, OP_LW, 6'h00, 0, 0, 0, eDec()));
      // IR fields change after DECODE; the latched copy must keep driving lw
      rows.push_back(mkRow(0, OP_R, F_ADD, 1, 0, 0, B_EXT | B_SRC | cs(3'd4, 3'd2)));
      rows.push_back(mkRow(0, OP_R, F_ADD, 0, 0, 0, eMem));
      rows.push_back(mkRow(0, OP_R, F_ADD, 0, 0, 0, eMem));
      rows.push_back(mkRow(0, OP_R, F_ADD, 1, 0, 0, eMem));
      rows.push_back(mkRow(0, OP_R, F_ADD, 0, 0, 0, B_REGWR | B_EXT | B_SRC | B_M2R | cs(3'd4, 3'd4)));
      rows.push_back(mkRow(0, OP_R, F_ADD, 0, 0, 0, eWait()));
      foreach (rows[i]) begin
         drive(rows[i]); #1;
         checks++;
         if (obs !== rows[i].exp) begin
            errors++;
            $display("[TB] FAIL lw_stall row %0d: got %h expected %h", i, obs, rows[i].exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      row_t rows[$];
      rows.push_back(mkRow(0, OP_SW, 6'h00, 1, 0, 0, eGo()));
      rows.push_back(mkRow(0, OP_SW, 6'h00, 1, 0, 0, eDec()));
      rows.push_back(mkRow(0, OP_SW, 6'h00, 1, 0, 0, B_EXT | B_SRC | cs(3'd4, 3'd2)));
      rows.push_back(mkRow(0, OP_SW, 6'h00, 1, 0, 0, B_REQ | B_MEMWR | B_IORD | B_EXT | B_SRC | cs(3'd4, 3'd3)));
      rows.push_back(mkRow(0, OP_ADDI, 6'h00, 1, 0, 0, eGo()));
      rows.push_back(mkRow(0, OP_ADDI, 6'h00, 1, 0, 0, eDec()));
      rows.push_back(mkRow(0, OP_ADDI, 6'h00, 1, 0, 0, B_EXT | B_SRC | cs(3'd2, 3'd2)));
      rows.push_back(mkRow(0, OP_ADDI, 6'h00, 1, 0, 0, B_REGWR | B_EXT | B_SRC | cs(3'd2, 3'd4)));
      rows.push_back(mkRow(0, OP_ADDI, 6'h00, 0, 0, 0, eWait()));
      foreach (rows[i]) begin
         drive(rows[i]); #1;
         checks++;
         if (obs !== rows[i].exp) begin
            errors++;
            $display("[TB] FAIL sw_addi row %0d: got %h expected %h", i, obs, rows[i].exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_rtype_alu();
      row_t rows[$];
      logic [5:0] funs[8];
      logic [2:0] ctrs[8];
      funs = '{6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h00, 6'h2a, 6'h2b};
      ctrs = '{3'd4, 3'd6, 3'd6, 3'd0, 3'd1, 3'd5, 3'd3, 3'd7};
      for (int k = 0; k < 8; k++) begin
         rows.push_back(mkRow(0, OP_R, funs[k], 1, 0, 0, eGo()));
         rows.push_back(mkRow(0, OP_R, funs[k], 1, 0, 0, eDec()));
         rows.push_back(mkRow(0, OP_R, funs[k], 1, 0, 0, cs(ctrs[k], 3'd2)));
         rows.push_back(mkRow(0, OP_R, funs[k], 1, 0, 0, B_REGWR | B_REGDST | cs(ctrs[k], 3'd4)));
      end
      rows.push_back(mkRow(0, OP_R, F_ADD, 0, 0, 0, eWait()));
      foreach (rows[i]) begin
         drive(rows[i]); #1;
         checks++;
         if (obs !== rows[i].exp) begin
            errors++;
            $display("[TB] FAIL rtype_alu row %0d: got %h expected %h", i, obs, rows[i].exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branches();
      row_t rows[$];
      logic [5:0] ops[7];
      logic       eqs[7];
      logic       sgs[7];
      logic       tkn[7];
      ops = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE, OP_BGTZ, OP_BGTZ, OP_BGTZ};
      eqs = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0,    1'b0,    1'b1};
      sgs = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0,    1'b1,    1'b0};
      tkn = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1,    1'b0,    1'b0};
      for (int k = 0; k < 7; k++) begin
         rows.push_back(mkRow(0, ops[k], 6'h00, 1, eqs[k], sgs[k], eGo()));
         rows.push_back(mkRow(0, ops[k], 6'h00, 1, eqs[k], sgs[k], eDec()));
         rows.push_back(mkRow(0, ops[k], 6'h00, 1, eqs[k], sgs[k],
                              (tkn[k] ? (B_PCW | B_NPC) : 18'h0) | cs(3'd6, 3'd2)));
      end
      rows.push_back(mkRow(0, OP_BEQ, 6'h00, 0, 1, 0, eWait()));
      foreach (rows[i]) begin
         drive(rows[i]); #1;
         checks++;
         if (obs !== rows[i].exp) begin
            errors++;
            $display("[TB] FAIL branch row %0d: got %h expected %h", i, obs, rows[i].exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      row_t rows[$];
      rows.push_back(mkRow(0, 6'h3f, 6'h00, 1, 0, 0, eGo()));
      rows.push_back(mkRow(0, 6'h3f, 6'h00, 1, 0, 0, B_ILL | cs(3'd0, 3'd1)));
      rows.push_back(mkRow(0, 6'h3f, 6'h00, 0, 0, 0, eWait()));
      rows.push_back(mkRow(0, OP_R, 6'h01, 1, 0, 0, eGo()));
      rows.push_back(mkRow(0, OP_R, 6'h01, 1, 0, 0, B_ILL | cs(3'd0, 3'd1)));
      rows.push_back(mkRow(0, OP_R, 6'h01, 0, 0, 0, eWait()));
      rows.push_back(mkRow(0, 6'h02, 6'h20, 1, 0, 0, eGo()));
      rows.push_back(mkRow(0, 6'h02, 6'h20, 1, 0, 0, B_ILL | cs(3'd0, 3'd1)));
      // the all-zero word decodes as sll
      rows.push_back(mkRow(0, OP_R, 6'h00, 1, 0, 0, eGo()));
      rows.push_back(mkRow(0, OP_R, 6'h00, 1, 0, 0, eDec()));
      rows.push_back(mkRow(0, OP_R, 6'h00, 1, 0, 0, cs(3'd5, 3'd2)));
      rows.push_back(mkRow(0, OP_R, 6'h00, 1, 0, 0, B_REGWR | B_REGDST | cs(3'd5, 3'd4)));
      rows.push_back(mkRow(0, OP_R, 6'h00, 0, 0, 0, eWait()));
      foreach (rows[i]) begin
         drive(rows[i]); #1;
         checks++;
         if (obs !== rows[i].exp) begin
            errors++;
            $display("[TB] FAIL illegal row %0d: got %h expected %h", i, obs, rows[i].exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_during_sw();
      row_t rows[$];
      rows.push_back(mkRow(0, OP_SW, 6'h00, 1, 0, 0, eGo()));
      rows.push_back(mkRow(0, OP_SW, 6'h00, 1, 0, 0, eDec()));
      rows.push_back(mkRow(0, OP_SW, 6'h00, 1, 0, 0, B_EXT | B_SRC | cs(3'd4, 3'd2)));
      rows.push_back(mkRow(0, OP_SW, 6'h00, 0, 0, 0, B_REQ | B_MEMWR | B_IORD | B_EXT | B_SRC | cs(3'd4, 3'd3)));
      rows.push_back(mkRow(1, OP_SW, 6'h00, 0, 0, 0, 18'h0));
      rows.push_back(mkRow(0, OP_SW, 6'h00, 0, 0, 0, eWait()));
      rows.push_back(mkRow(0, OP_SW, 6'h00, 0, 0, 0, eWait()));
      foreach (rows[i]) begin
         drive(rows[i]); #1;
         checks++;
         if (obs !== rows[i].exp) begin
            errors++;
            $display("[TB] FAIL reset_sw row %0d: got %h expected %h", i, obs, rows[i].exp);
         end
         @(posedge clk); #1;
      end
   endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
   task automatic test_perf_counters();
      row_t rows[$];
      rows.push_back(mkRow(1, OP_R, F_ADD, 0, 0, 0, 18'h0));
      repeat (4) rows.push_back(mkRow(0, OP_R, F_ADD, 1, 0, 0, 18'h0));
      repeat (3) rows.push_back(mkRow(0, OP_SW, 6'h00, 1, 0, 0, 18'h0));
      rows.push_back(mkRow(0, OP_SW, 6'h00, 0, 0, 0, 18'h0));
      rows.push_back(mkRow(0, OP_SW, 6'h00, 1, 0, 0, 18'h0));
      repeat (3) rows.push_back(mkRow(0, OP_BEQ, 6'h00, 1, 1, 0, 18'h0));
      foreach (rows[i]) begin
         drive(rows[i]);
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state !== 3'd0) begin
         errors++;
         $display("[TB] FAIL perf_state: got %0d expected 0", state);
      end
      checks++;
      if (cycle_cnt !== 32'd12) begin
         errors++;
         $display("[TB] FAIL perf_cycle_cnt: got %0d expected 12", cycle_cnt);
      end
      checks++;
      if (instr_cnt !== 32'd3) begin
         errors++;
         $display("[TB] FAIL perf_instr_cnt: got %0d expected 3", instr_cnt);
      end
      checks++;
      if (stall_cnt !== 32'd1) begin
         errors++;
         $display("[TB] FAIL perf_stall_cnt: got %0d expected 1", stall_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_zero_wait_add();
      test_lw_stall();
      test_back_to_back();
      test_rtype_alu();
      test_branches();
      test_illegal();
      test_reset_during_sw();
`ifdef MULTICYCLE_CTRL_PERF_EN
      test_perf_counters();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
